// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding and block/address
// width helpers so caches, memory and arbiter agree on the same geometry.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam int DEF_LINE_SIZE    = 32;
  localparam int DEF_BLOCK_SIZE   = 2;
  localparam int DEF_ADDRESS_SIZE = 32;

  function automatic int blk_w(input int line_size, input int block_size);
    return (1 << block_size) * line_size;
  endfunction

  function automatic int baddr_w(input int address_size, input int block_size);
    return address_size - block_size - 2;
  endfunction

  localparam int BLK_W   = blk_w(DEF_LINE_SIZE, DEF_BLOCK_SIZE);
  localparam int BADDR_W = baddr_w(DEF_ADDRESS_SIZE, DEF_BLOCK_SIZE);

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// 2-way round-robin grant select; the priority pointer moves away from the
// requester that was just served when the transaction finishes.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_done,
  input  logic       i_done_gnt,
  output logic       o_gnt
);

  logic r_ptr;

  // Contention resolved by the pointer; otherwise the lone requester wins.
  assign o_gnt = (&i_req) ? r_ptr : i_req[1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_ptr <= 1'b0;
    else if (i_done) r_ptr <= ~i_done_gnt;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block-granular memory port between the I-cache (rq0) and D-cache
// (rq1): round-robin, one outstanding transaction, watchdog on memory latency.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_SIZE    = DEF_LINE_SIZE,
  parameter int BLOCK_SIZE   = DEF_BLOCK_SIZE,
  parameter int ADDRESS_SIZE = DEF_ADDRESS_SIZE,
  parameter int TIMEOUT      = 255,
  localparam int BW = blk_w(LINE_SIZE, BLOCK_SIZE),
  localparam int AW = baddr_w(ADDRESS_SIZE, BLOCK_SIZE)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          rq0_read_i,
  input  logic          rq0_wr_i,
  input  logic [AW-1:0] rq0_address_i,
  input  logic [BW-1:0] rq0_write_data_i,
  output logic [BW-1:0] rq0_read_data_o,
  output logic          rq0_busywait_o,
  input  logic          rq1_read_i,
  input  logic          rq1_wr_i,
  input  logic [AW-1:0] rq1_address_i,
  input  logic [BW-1:0] rq1_write_data_i,
  output logic [BW-1:0] rq1_read_data_o,
  output logic          rq1_busywait_o,
  output logic          m_read_o,
  output logic          m_wr_o,
  output logic [AW-1:0] m_address_o,
  output logic [BW-1:0] m_write_data_o,
  input  logic [BW-1:0] m_read_data_i,
  input  logic          m_busywait_i,
  output logic          err_o
);

  localparam logic [8:0] TO_CNT = 9'(TIMEOUT);

  arb_state_t    r_state, w_state_nxt;
  logic          r_gnt;
  logic          r_op_rd, r_op_wr;
  logic [AW-1:0] r_addr;
  logic [BW-1:0] r_wdata;
  logic [BW-1:0] r_rdata0, r_rdata1;
  logic [7:0]    r_wd;
  logic          r_err;

  logic          w_req0, w_req1, w_any_req;
  logic          w_gnt_sel;
  logic          w_active;
  logic          w_done;
  logic [8:0]    w_wd_inc;
  logic          w_wd_hit;

  assign w_req0    = rq0_read_i | rq0_wr_i;
  assign w_req1    = rq1_read_i | rq1_wr_i;
  assign w_any_req = w_req0 | w_req1;
  assign w_done    = (r_state == ST_DONE);
  assign w_active  = (r_state == ST_ISSUE) | (r_state == ST_WAIT);

  // Timeout fires on the WAIT cycle whose increment reaches TIMEOUT, so the
  // arbiter spends exactly TIMEOUT cycles in WAIT before giving up.
  assign w_wd_inc = {1'b0, r_wd} + 9'd1;
  assign w_wd_hit = (w_wd_inc == TO_CNT);

  rr_arb2 u_rr (
    .i_clk      (clk_i),
    .i_rst      (reset_i),
    .i_req      ({w_req1, w_req0}),
    .i_done     (w_done),
    .i_done_gnt (r_gnt),
    .o_gnt      (w_gnt_sel)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_req) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (!m_busywait_i || w_wd_hit) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Request latch: read and write together is a write.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_gnt   <= 1'b0;
      r_op_rd <= 1'b0;
      r_op_wr <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == ST_IDLE && w_any_req) begin
      r_gnt   <= w_gnt_sel;
      r_op_wr <= w_gnt_sel ? rq1_wr_i : rq0_wr_i;
      r_op_rd <= w_gnt_sel ? (rq1_read_i & ~rq1_wr_i) : (rq0_read_i & ~rq0_wr_i);
      r_addr  <= w_gnt_sel ? rq1_address_i : rq0_address_i;
      r_wdata <= w_gnt_sel ? rq1_write_data_i : rq0_write_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wd     <= '0;
      r_err    <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          r_wd <= r_wd + 8'd1;
          if (!m_busywait_i) begin
            if (r_op_rd && r_gnt)  r_rdata1 <= m_read_data_i;
            if (r_op_rd && !r_gnt) r_rdata0 <= m_read_data_i;
          end else if (w_wd_hit) begin
            r_err <= 1'b1;
          end
        end
        ST_DONE: r_wd <= '0;
        default: ;
      endcase
    end
  end

  assign m_read_o        = r_op_rd & w_active;
  assign m_wr_o          = r_op_wr & w_active;
  assign m_address_o     = r_addr;
  assign m_write_data_o  = r_wdata;
  assign err_o           = r_err;
  assign rq0_read_data_o = r_rdata0;
  assign rq1_read_data_o = r_rdata1;

  // The granted requester is released only in DONE; everyone else stays stalled.
  assign rq0_busywait_o = w_req0 & ~(w_done & ~r_gnt);
  assign rq1_busywait_o = w_req1 & ~(w_done & r_gnt);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small latency-programmable memory model.
module tb_mem_arbiter;

  localparam int BW = 128;
  localparam int AW = 28;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          rq0_read_i = 1'b0, rq0_wr_i = 1'b0;
  logic [AW-1:0] rq0_address_i = '0;
  logic [BW-1:0] rq0_write_data_i = '0;
  logic [BW-1:0] rq0_read_data_o;
  logic          rq0_busywait_o;
  logic          rq1_read_i = 1'b0, rq1_wr_i = 1'b0;
  logic [AW-1:0] rq1_address_i = '0;
  logic [BW-1:0] rq1_write_data_i = '0;
  logic [BW-1:0] rq1_read_data_o;
  logic          rq1_busywait_o;
  logic          m_read_o, m_wr_o;
  logic [AW-1:0] m_address_o;
  logic [BW-1:0] m_write_data_o;
  logic [BW-1:0] mem_rdata = '0;
  logic          m_busy = 1'b0;
  logic          err_o;

  int   n_chk = 0;
  int   n_fail = 0;
  int   mem_lat = 0;
  int   mem_cnt = 0;
  logic mem_act = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(8)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .rq0_read_i(rq0_read_i), .rq0_wr_i(rq0_wr_i), .rq0_address_i(rq0_address_i),
    .rq0_write_data_i(rq0_write_data_i), .rq0_read_data_o(rq0_read_data_o),
    .rq0_busywait_o(rq0_busywait_o),
    .rq1_read_i(rq1_read_i), .rq1_wr_i(rq1_wr_i), .rq1_address_i(rq1_address_i),
    .rq1_write_data_i(rq1_write_data_i), .rq1_read_data_o(rq1_read_data_o),
    .rq1_busywait_o(rq1_busywait_o),
    .m_read_o(m_read_o), .m_wr_o(m_wr_o), .m_address_o(m_address_o),
    .m_write_data_o(m_write_data_o), .m_read_data_i(mem_rdata),
    .m_busywait_i(m_busy), .err_o(err_o)
  );

  // Memory: raises busywait the cycle after it sees an op, holds it for mem_lat cycles.
  always @(posedge clk) begin
    if (!(m_read_o | m_wr_o)) begin
      mem_act <= 1'b0;
      m_busy  <= 1'b0;
    end else if (!mem_act) begin
      mem_act <= 1'b1;
      mem_cnt <= mem_lat;
      m_busy  <= (mem_lat > 0);
    end else if (mem_cnt > 1) begin
      mem_cnt <= mem_cnt - 1;
    end else begin
      m_busy <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    rq0_read_i = 1'b0; rq0_wr_i = 1'b0;
    rq1_read_i = 1'b0; rq1_wr_i = 1'b0;
  endtask

  // Ticks until requester `who` is released; cyc = ticks taken (40 = bound hit).
  task automatic wait_free(input int who, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while ((who == 0 ? rq0_busywait_o : rq1_busywait_o) && cyc < 40);
  endtask

  // Ticks until either requester is released; who = 0/1, 2 if both, 3 on bound.
  task automatic serve(output int who, output int cyc);
    cyc = 0;
    who = 3;
    while (who == 3 && cyc < 40) begin
      tick();
      cyc++;
      if (!rq0_busywait_o && rq1_busywait_o)      who = 0;
      else if (rq0_busywait_o && !rq1_busywait_o) who = 1;
      else if (!rq0_busywait_o && !rq1_busywait_o) who = 2;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation bound exceeded");
    $fatal(1);
  end

  initial begin
    int cyc, who;

    tick(); tick();
    chk("rst_m_read", m_read_o, 1'b0);
    chk("rst_m_wr", m_wr_o, 1'b0);
    chk("rst_m_addr", m_address_o, '0);
    chk("rst_m_wdata", m_write_data_o, '0);
    chk("rst_rdata0", rq0_read_data_o, '0);
    chk("rst_rdata1", rq1_read_data_o, '0);
    chk("rst_err", err_o, 1'b0);
    reset_i = 1'b0;
    tick();

    // Single read: 4 busy cycles -> released in cycle 7.
    mem_lat = 4; mem_rdata = 128'h3;
    rq0_read_i = 1'b1; rq0_address_i = 28'h0000009;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) begin
        chk("rd_issue_m_read", m_read_o, 1'b1);
        chk("rd_issue_addr", m_address_o, 28'h9);
      end
      if (k == 6) begin
        chk("rd_wait_m_read", m_read_o, 1'b1);
        chk("rd_wait_bw0", rq0_busywait_o, 1'b1);
      end
      if (k == 7) begin
        chk("rd_done_bw0", rq0_busywait_o, 1'b0);
        chk("rd_done_m_read", m_read_o, 1'b0);
        chk("rd_done_data", rq0_read_data_o, 128'h3);
        chk("rd_idle_bw1", rq1_busywait_o, 1'b0);
      end
    end
    clr_req(); tick();

    // Write with read also high: treated as a write, read data untouched.
    mem_lat = 2; mem_rdata = 128'hDEAD;
    rq1_wr_i = 1'b1; rq1_read_i = 1'b1;
    rq1_address_i = 28'h20; rq1_write_data_i = 128'h1234;
    tick();
    chk("wr_m_wr", m_wr_o, 1'b1);
    chk("wr_m_read", m_read_o, 1'b0);
    chk("wr_addr", m_address_o, 28'h20);
    chk("wr_wdata", m_write_data_o, 128'h1234);
    wait_free(1, cyc);
    chk("wr_latency", cyc, 4);
    chk("wr_rdata1_keep", rq1_read_data_o, '0);
    clr_req(); tick();

    // Timeout: memory never answers; DONE after 8 WAIT cycles.
    mem_lat = 1000; mem_rdata = 128'hBAD;
    rq1_read_i = 1'b1; rq1_address_i = 28'h5;
    wait_free(1, cyc);
    chk("to_latency", cyc, 10);
    chk("to_err", err_o, 1'b1);
    chk("to_rdata1_keep", rq1_read_data_o, '0);
    clr_req(); tick();
    chk("to_err_sticky", err_o, 1'b1);

    // Normal zero-latency read after the timeout.
    mem_lat = 0; mem_rdata = 128'hA5A5;
    rq0_read_i = 1'b1; rq0_address_i = 28'h7;
    wait_free(0, cyc);
    chk("post_to_latency", cyc, 3);
    chk("post_to_data", rq0_read_data_o, 128'hA5A5);
    chk("post_to_err", err_o, 1'b1);
    clr_req(); tick();

    // Asynchronous reset in the middle of WAIT.
    mem_lat = 1000;
    rq1_read_i = 1'b1; rq1_address_i = 28'h55;
    tick(); tick(); tick();
    chk("ar_pre_m_read", m_read_o, 1'b1);
    reset_i = 1'b1;
    #1;
    chk("ar_m_read", m_read_o, 1'b0);
    chk("ar_err", err_o, 1'b0);
    chk("ar_rdata0", rq0_read_data_o, '0);
    chk("ar_bw1_held", rq1_busywait_o, 1'b1);
    clr_req(); tick();
    reset_i = 1'b0;
    tick();

    // Contention: both held -> rq0, rq1, rq0.
    mem_lat = 1; mem_rdata = 128'h5;
    rq0_read_i = 1'b1; rq0_address_i = 28'h100;
    rq1_read_i = 1'b1; rq1_address_i = 28'h200;
    serve(who, cyc);
    chk("ct1_who", who, 0);
    chk("ct1_latency", cyc, 4);
    serve(who, cyc);
    chk("ct2_who", who, 1);
    chk("ct2_latency", cyc, 5);
    chk("ct2_rdata1", rq1_read_data_o, 128'h5);
    serve(who, cyc);
    chk("ct3_who", who, 0);
    clr_req(); tick();

    // Requester drops mid-transaction; op completes, pending rq1 goes next.
    mem_lat = 3; mem_rdata = 128'h77;
    rq0_read_i = 1'b1; rq0_address_i = 28'h33;
    tick(); tick();
    rq0_read_i = 1'b0;
    rq1_read_i = 1'b1; rq1_address_i = 28'h44;
    #1;
    chk("dr_bw0", rq0_busywait_o, 1'b0);
    chk("dr_m_read", m_read_o, 1'b1);
    chk("dr_addr", m_address_o, 28'h33);
    for (int k = 0; k < 4; k++) tick();
    chk("dr_done_data", rq0_read_data_o, 128'h77);
    chk("dr_done_m_read", m_read_o, 1'b0);
    chk("dr_done_bw1", rq1_busywait_o, 1'b1);
    mem_lat = 0; mem_rdata = 128'h88;
    tick(); tick();
    chk("dr_next_addr", m_address_o, 28'h44);
    chk("dr_next_m_read", m_read_o, 1'b1);
    wait_free(1, cyc);
    chk("dr_next_latency", cyc, 2);
    chk("dr_next_data", rq1_read_data_o, 128'h88);
    clr_req(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
